// File: rtl/datamemory_store_unit.sv
// Data memory store unit: buffers one store per PE, round-robin arbitrates them onto one registered write port.
// Optional DATAMEM_STORE_RANGE_CHK_EN drops out-of-range stores and raises a sticky Err_Out.
module datamemory_store_unit #(
  parameter int unsigned NB_ROWS = 4,
  parameter int unsigned NB_COLS = 4,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NB_ROWS*NB_COLS-1:0]          Store_Valid_In,
  input  logic [NB_ROWS*NB_COLS-1:0][31:0]    Store_Addr_In,
  input  logic [NB_ROWS*NB_COLS-1:0][31:0]    Store_Data_In,
  output logic [NB_ROWS*NB_COLS-1:0]          Store_Ready_Out,
  output logic                                Busy_Out,
  output logic                                Mem_We_Out,
  output logic [ADDR_W-1:0]                   Mem_Addr_Out,
  output logic [31:0]                         Mem_Data_Out
`ifdef DATAMEM_STORE_RANGE_CHK_EN
  ,
  output logic                                Err_Out
`endif
);

  localparam int unsigned N     = NB_ROWS * NB_COLS;
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]             pend;
  logic [N-1:0][ADDR_W-1:0] addr_q;
  logic [N-1:0][31:0]       data_q;
  logic [PTR_W-1:0]         rr_ptr;

  logic [N-1:0]             gnt;
  logic                     gnt_any;
  logic [PTR_W-1:0]         g_idx;
  logic [PTR_W-1:0]         rr_next;
  logic [N-1:0]             handshake;
  logic [N-1:0]             accept;

  // First pending slot found scanning cyclically from rr_ptr.
  always_comb begin : arb
    int unsigned idx;
    gnt     = '0;
    gnt_any = 1'b0;
    g_idx   = '0;
    rr_next = rr_ptr;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!gnt_any && pend[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        g_idx    = PTR_W'(idx);
        rr_next  = PTR_W'((idx + 1) % N);
      end
    end
  end

  assign Store_Ready_Out = ~pend | gnt;
  assign Busy_Out        = |pend;
  assign handshake       = Store_Valid_In & Store_Ready_Out;

`ifdef DATAMEM_STORE_RANGE_CHK_EN
  logic [N-1:0] oob;
  logic         err_q;

  always_comb begin
    oob = '0;
    for (int unsigned i = 0; i < N; i++) begin
      oob[i] = |Store_Addr_In[i][31:ADDR_W];
    end
  end

  // Out-of-range requests still complete the handshake but never occupy a slot.
  assign accept = handshake & ~oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (|(handshake & oob)) begin
      err_q <= 1'b1;
    end
  end

  assign Err_Out = err_q;
`else
  logic unused_addr_hi;

  always_comb begin
    unused_addr_hi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      unused_addr_hi = unused_addr_hi ^ (^Store_Addr_In[i][31:ADDR_W]);
    end
  end

  assign accept = handshake;
`endif

  // A same-edge capture takes priority over the grant clearing the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (accept[i]) begin
          pend[i]   <= 1'b1;
          addr_q[i] <= Store_Addr_In[i][ADDR_W-1:0];
          data_q[i] <= Store_Data_In[i];
        end else if (gnt[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      Mem_We_Out   <= 1'b0;
      Mem_Addr_Out <= '0;
      Mem_Data_Out <= '0;
    end else if (gnt_any) begin
      rr_ptr       <= rr_next;
      Mem_We_Out   <= 1'b1;
      Mem_Addr_Out <= addr_q[g_idx];
      Mem_Data_Out <= data_q[g_idx];
    end else begin
      Mem_We_Out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datamemory_store_unit.sv
// Directed self-checking bench for datamemory_store_unit (honours DATAMEM_STORE_RANGE_CHK_EN).
module tb_datamemory_store_unit;

  localparam int unsigned N = 16;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        st_valid;
  logic [N-1:0][31:0]  st_addr;
  logic [N-1:0][31:0]  st_data;
  logic [N-1:0]        st_ready;
  logic                busy;
  logic                mem_we;
  logic [11:0]         mem_addr;
  logic [31:0]         mem_data;
`ifdef DATAMEM_STORE_RANGE_CHK_EN
  logic                err;
`endif

  int n_checks;
  int n_errors;

  datamemory_store_unit #(.NB_ROWS(4), .NB_COLS(4), .ADDR_W(12)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Store_Valid_In  (st_valid),
    .Store_Addr_In   (st_addr),
    .Store_Data_In   (st_data),
    .Store_Ready_Out (st_ready),
    .Busy_Out        (busy),
    .Mem_We_Out      (mem_we),
    .Mem_Addr_Out    (mem_addr),
    .Mem_Data_Out    (mem_data)
`ifdef DATAMEM_STORE_RANGE_CHK_EN
    ,
    .Err_Out         (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_ready;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    st_valid = '0;
    st_addr  = '0;
    st_data  = '0;

    // Reset state while rst_n is low
    #2;
    chk("rst_ready", 32'(st_ready), 32'h0000_FFFF);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    #10 rst_n = 1'b1;

    // Idle: no writes for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_we", 32'(mem_we), 32'd0);
    end
    chk("idle_ready", 32'(st_ready), 32'h0000_FFFF);
    chk("idle_busy",  32'(busy), 32'd0);

    // Single store from PE3
    st_valid[3] = 1'b1;
    st_addr[3]  = 32'h010;
    st_data[3]  = 32'hDEAD_BEEF;
    tick();
    st_valid = '0;
    chk("pe3_busy_t",  32'(busy), 32'd1);
    chk("pe3_we_t",    32'(mem_we), 32'd0);
    chk("pe3_ready_t", 32'(st_ready), 32'h0000_FFFF);
    tick();
    chk("pe3_we",   32'(mem_we), 32'd1);
    chk("pe3_addr", 32'(mem_addr), 32'h010);
    chk("pe3_data", mem_data, 32'hDEAD_BEEF);
    chk("pe3_busy", 32'(busy), 32'd0);
    tick();
    chk("pe3_we_off", 32'(mem_we), 32'd0);

    // Mid-operation reset discards pending PE1 store (rr_ptr=4 so PE0 goes first)
    st_valid    = 16'h0003;
    st_addr[0]  = 32'h111;
    st_data[0]  = 32'hAAAA_0000;
    st_addr[1]  = 32'h222;
    st_data[1]  = 32'hBBBB_1111;
    tick();
    st_valid = '0;
    tick();
    chk("mid_we_pre",   32'(mem_we), 32'd1);
    chk("mid_addr_pre", 32'(mem_addr), 32'h111);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(mem_we), 32'd0);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    chk("mid_rst_data",  mem_data, 32'd0);
    chk("mid_rst_busy",  32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(st_ready), 32'h0000_FFFF);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_post_we",   32'(mem_we), 32'd0);
    chk("mid_post_busy", 32'(busy), 32'd0);

    // All 16 PEs at once: writes PE0..PE15 in order
    for (int i = 0; i < N; i++) begin
      st_addr[i] = 32'(i);
      st_data[i] = 32'h100 + 32'(i);
    end
    st_valid = '1;
    tick();
    st_valid = '0;
    chk("all_ready_t", 32'(st_ready), 32'h0000_0001);
    chk("all_busy_t",  32'(busy), 32'd1);
    chk("all_we_t",    32'(mem_we), 32'd0);
    for (int k = 0; k < N; k++) begin
      tick();
      exp_ready = (k >= 14) ? 32'h0000_FFFF : ((32'd1 << (k + 2)) - 32'd1);
      chk("all_we",    32'(mem_we), 32'd1);
      chk("all_addr",  32'(mem_addr), 32'(k));
      chk("all_data",  mem_data, 32'h100 + 32'(k));
      chk("all_ready", 32'(st_ready), exp_ready);
      chk("all_busy",  32'(busy), (k < 15) ? 32'd1 : 32'd0);
    end
    tick();
    chk("all_we_off", 32'(mem_we), 32'd0);

    // PE5 streams 4 stores back to back
    st_valid[5] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      st_addr[5] = 32'h20 + 32'(j);
      st_data[5] = 32'h500 + 32'(j);
      tick();
      chk("pe5_ready", 32'(st_ready[5]), 32'd1);
      if (j > 0) begin
        chk("pe5_we",   32'(mem_we), 32'd1);
        chk("pe5_addr", 32'(mem_addr), 32'h20 + 32'(j - 1));
        chk("pe5_data", mem_data, 32'h500 + 32'(j - 1));
      end
    end
    st_valid = '0;
    tick();
    chk("pe5_we_last",   32'(mem_we), 32'd1);
    chk("pe5_addr_last", 32'(mem_addr), 32'h23);
    chk("pe5_busy",      32'(busy), 32'd0);

    // PE6 store moves rr_ptr to 7
    st_valid[6] = 1'b1;
    st_addr[6]  = 32'h066;
    st_data[6]  = 32'h6666;
    tick();
    st_valid = '0;
    tick();
    chk("pe6_addr", 32'(mem_addr), 32'h066);

    // PE2 and PE9 together from rr_ptr=7: PE9 first, same address, PE2 lands last
    st_valid[2] = 1'b1;
    st_addr[2]  = 32'h0AA;
    st_data[2]  = 32'h2222;
    st_valid[9] = 1'b1;
    st_addr[9]  = 32'h0AA;
    st_data[9]  = 32'h9999;
    tick();
    st_valid = '0;
    chk("rr_ready", 32'(st_ready), 32'h0000_FFFB);
    tick();
    chk("rr_first_we",   32'(mem_we), 32'd1);
    chk("rr_first_data", mem_data, 32'h9999);
    tick();
    chk("rr_second_we",   32'(mem_we), 32'd1);
    chk("rr_second_addr", 32'(mem_addr), 32'h0AA);
    chk("rr_second_data", mem_data, 32'h2222);
    chk("rr_busy",        32'(busy), 32'd0);

    // Upper address bits set
    st_valid[0] = 1'b1;
    st_addr[0]  = 32'h0000_1004;
    st_data[0]  = 32'hCAFE_F00D;
`ifdef DATAMEM_STORE_RANGE_CHK_EN
    chk("err_pre", 32'(err), 32'd0);
    chk("oob_ready", 32'(st_ready[0]), 32'd1);
    tick();
    st_valid = '0;
    chk("oob_err",  32'(err), 32'd1);
    chk("oob_busy", 32'(busy), 32'd0);
    tick();
    chk("oob_we",   32'(mem_we), 32'd0);
    chk("oob_err_sticky", 32'(err), 32'd1);
`else
    tick();
    st_valid = '0;
    chk("wrap_busy", 32'(busy), 32'd1);
    tick();
    chk("wrap_we",   32'(mem_we), 32'd1);
    chk("wrap_addr", 32'(mem_addr), 32'h004);
    chk("wrap_data", mem_data, 32'hCAFE_F00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
